// File: rtl/dtc_seq_walker.sv
// Table-driven decision-tree classifier: walks a run-time-loaded node table one node per cycle
// between a valid/ready feature-vector input and a valid/ready class output.
module dtc_seq_walker #(
    parameter  int unsigned N_FEAT    = 8,
    parameter  int unsigned N_CLASS_W = 2,
    parameter  int unsigned N_NODES   = 64,
    parameter  int unsigned MAX_STEPS = 16,
    localparam int unsigned NODE_AW   = $clog2(N_NODES),
    localparam int unsigned STEP_W    = $clog2(MAX_STEPS + 1),
    localparam int unsigned FIDX_W    = $clog2(N_FEAT),
    localparam int unsigned ENTRY_W   = 1 + FIDX_W + 2 * NODE_AW + N_CLASS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_FEAT-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_CLASS_W-1:0] out_class,
    output logic                 out_err,
    output logic [STEP_W-1:0]    out_steps,
    input  logic                 cfg_we,
    input  logic [NODE_AW-1:0]   cfg_addr,
    input  logic [ENTRY_W-1:0]   cfg_data,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t               state, state_n;
    logic [ENTRY_W-1:0]   tbl [N_NODES];
    logic [N_FEAT-1:0]    feat;
    logic [NODE_AW-1:0]   cur, cur_n;
    logic [STEP_W-1:0]    steps, steps_n;
    logic [N_CLASS_W-1:0] cls_q, cls_n;
    logic                 err_q, err_n;
    logic                 cfg_err_q;

    logic [ENTRY_W-1:0]   ent;
    logic                 e_leaf;
    logic [FIDX_W-1:0]    e_fidx;
    logic [NODE_AW-1:0]   e_lo, e_hi, child;
    logic [N_CLASS_W-1:0] e_cls;
    logic                 fidx_ok, child_ok, addr_ok, cfg_ok;

    assign ent    = tbl[cur];
    assign e_leaf = ent[ENTRY_W-1];
    assign e_fidx = ent[ENTRY_W-2 -: FIDX_W];
    assign e_lo   = ent[2*NODE_AW+N_CLASS_W-1 -: NODE_AW];
    assign e_hi   = ent[NODE_AW+N_CLASS_W-1 -: NODE_AW];
    assign e_cls  = ent[N_CLASS_W-1:0];
    assign child  = feat[e_fidx] ? e_hi : e_lo;

    // Range checks only exist when the field width can encode out-of-range values.
    if (N_FEAT == (1 << FIDX_W)) begin : g_fidx_full
        assign fidx_ok = 1'b1;
    end else begin : g_fidx_part
        assign fidx_ok = (32'(e_fidx) < N_FEAT);
    end

    if (N_NODES == (1 << NODE_AW)) begin : g_node_full
        assign child_ok = 1'b1;
        assign addr_ok  = 1'b1;
    end else begin : g_node_part
        assign child_ok = (32'(child) < N_NODES);
        assign addr_ok  = (32'(cfg_addr) < N_NODES);
    end

    assign cfg_ok = cfg_we && (state == IDLE) && addr_ok;

    always_comb begin
        state_n = state;
        cur_n   = cur;
        steps_n = steps;
        cls_n   = cls_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = WALK;
                    cur_n   = '0;
                    steps_n = '0;
                end
            end
            WALK: begin
                if (e_leaf) begin
                    cls_n   = e_cls;
                    err_n   = 1'b0;
                    state_n = DONE;
                end else if (!fidx_ok || !child_ok) begin
                    cls_n   = '0;
                    err_n   = 1'b1;
                    state_n = DONE;
                end else if (steps == STEP_W'(MAX_STEPS)) begin
                    cls_n   = '0;
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    cur_n   = child;
                    steps_n = steps + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            feat      <= '0;
            cur       <= '0;
            steps     <= '0;
            cls_q     <= '0;
            err_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            steps     <= steps_n;
            cls_q     <= cls_n;
            err_q     <= err_n;
            cfg_err_q <= cfg_we && !((state == IDLE) && addr_ok);
            if (state == IDLE && in_valid) feat <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_NODES; i++) tbl[i] <= '0;
        end else if (cfg_ok) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_class = cls_q;
    assign out_err   = err_q;
    assign out_steps = steps;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_dtc_seq_walker.sv
// Bench for dtc_seq_walker: spec-level walk model checked every cycle, directed literal cases,
// random trees with stalls, plus a non-power-of-two instance for illegal-index cases.
module tb_dtc_seq_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err, cfg_we, cfg_err;
    logic [7:0]  in_data;
    logic [1:0]  out_class;
    logic [4:0]  out_steps;
    logic [5:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic        dir_ready, rnd_ready, rnd;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_err, b_cfg_we, b_cfg_err;
    logic [4:0]  b_in_data;
    logic [1:0]  b_out_class;
    logic [2:0]  b_out_steps;
    logic [5:0]  b_cfg_addr;
    logic [17:0] b_cfg_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end
    assign out_ready = rnd ? rnd_ready : dir_ready;

    dtc_seq_walker #(.N_FEAT(8), .N_CLASS_W(2), .N_NODES(64), .MAX_STEPS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
        .out_steps(out_steps), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err)
    );

    dtc_seq_walker #(.N_FEAT(5), .N_CLASS_W(2), .N_NODES(40), .MAX_STEPS(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_class(b_out_class), .out_err(b_out_err),
        .out_steps(b_out_steps), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
        .cfg_err(b_cfg_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: entry = {leaf[17], fidx[16:14], lo[13:8], hi[7:2], cls[1:0]}
    typedef struct packed {
        logic [1:0] cls;
        logic       err;
        logic [4:0] steps;
    } res_t;

    logic [17:0] mtab [64];
    res_t        mexp;
    bit          mbusy = 1'b0;
    bit          exp_cfgerr = 1'b0;
    bit          ev;
    int          acc_cyc = 0;

    function automatic res_t model(input logic [7:0] d);
        res_t        r;
        int          node;
        int          nxt;
        logic [17:0] e;
        r    = '0;
        node = 0;
        for (int s = 0; s <= 16; s++) begin
            e   = mtab[node];
            nxt = d[e[16:14]] ? int'(e[7:2]) : int'(e[13:8]);
            r.steps = 5'(s);
            if (e[17]) begin
                r.cls = e[1:0];
                return r;
            end
            if (int'(e[16:14]) >= 8 || nxt >= 64 || s == 16) begin
                r.err = 1'b1;
                return r;
            end
            node = nxt;
        end
        r.err = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            foreach (mtab[i]) mtab[i] = '0;
            mbusy      = 1'b0;
            exp_cfgerr = 1'b0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_cfg_err", cfg_err, 0);
            check("rst_out_class", out_class, 0);
            check("rst_out_err", out_err, 0);
            check("rst_out_steps", out_steps, 0);
        end else begin
            // result visible at the sample point before edge T+steps+2
            ev = mbusy && ((cyc - acc_cyc) >= int'(mexp.steps) + 1);
            check("in_ready", in_ready, !mbusy);
            check("out_valid", out_valid, ev);
            check("cfg_err", cfg_err, exp_cfgerr);
            if (ev) begin
                check("out_class", out_class, mexp.cls);
                check("out_err", out_err, mexp.err);
                check("out_steps", out_steps, mexp.steps);
            end
            exp_cfgerr = cfg_we && mbusy;
            if (cfg_we && !mbusy) mtab[cfg_addr] = cfg_data;
            if (ev && out_ready) begin
                mbusy = 1'b0;
            end else if (!mbusy && in_valid) begin
                mexp    = model(in_data);
                acc_cyc = cyc + 1;
                mbusy   = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [17:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        check("accept_wait", ok, 1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic get_result(input logic [1:0] c, input logic e, input logic [4:0] s, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
        end
        check({nm, "_seen"}, got, 1);
        check({nm, "_class"}, out_class, c);
        check({nm, "_err"}, out_err, e);
        check({nm, "_steps"}, out_steps, s);
        tick();
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
    endtask

    task automatic run_dir(input logic [7:0] d, input logic [1:0] c, input logic e, input logic [4:0] s,
                           input string nm);
        send(d);
        get_result(c, e, s, nm);
    endtask

    task automatic load_t2();
        cfg_write(6'd0, {1'b0, 3'd7, 6'd1, 6'd2, 2'd0});
        cfg_write(6'd1, {1'b1, 3'd0, 6'd0, 6'd0, 2'd1});
        cfg_write(6'd2, {1'b1, 3'd0, 6'd0, 6'd0, 2'd2});
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        check("drain_wait", ok, 1);
        tick();
    endtask

    task automatic rand_phase();
        logic [17:0] e;
        int          g;
        rnd = 1'b1;
        for (int t = 0; t < 8; t++) begin
            drain();
            for (int a = 0; a < 64; a++) begin
                e     = 18'($urandom);
                e[17] = t[0] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
                cfg_write(6'(a), e);
            end
            for (int v = 0; v < 250; v++) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    cfg_we   = ($urandom_range(0, 9) == 0);
                    cfg_addr = 6'($urandom);
                    cfg_data = 18'($urandom);
                    tick();
                end
                cfg_we = 1'b0;
                send(8'($urandom));
            end
        end
        drain();
        rnd = 1'b0;
    endtask

    task automatic b_cfg(input logic [5:0] a, input logic [17:0] d, input logic exp_err, input string nm);
        b_cfg_we = 1'b1; b_cfg_addr = a; b_cfg_data = d;
        tick();
        b_cfg_we = 1'b0;
        @(negedge clk);
        check(nm, b_cfg_err, exp_err);
        tick();
    endtask

    task automatic b_run(input logic [4:0] d, input logic [1:0] c, input logic e, input logic [2:0] s,
                         input string nm);
        int n = 0;
        check({nm, "_ready"}, b_in_ready, 1);
        b_in_valid = 1'b1; b_in_data = d;
        tick();
        b_in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (b_out_valid) begin n = i; break; end
        end
        // i-th sample point precedes edge T+i, so a k-step walk shows up at i = k+2
        check({nm, "_lat"}, n, 32'(s) + 2);
        check({nm, "_class"}, b_out_class, c);
        check({nm, "_err"}, b_out_err, e);
        check({nm, "_steps"}, b_out_steps, s);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        dir_ready = 1'b0; rnd = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_cfg_we = 1'b0; b_cfg_addr = '0; b_cfg_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        run_dir(8'h00, 2'd0, 1'b1, 5'd16, "cleared_timeout");

        load_t2();
        run_dir(8'h80, 2'd2, 1'b0, 5'd1, "t2_bit7_hi");
        run_dir(8'h7F, 2'd1, 1'b0, 5'd1, "t2_bit7_lo");

        send(8'h80);
        cfg_write(6'd2, {1'b1, 3'd0, 6'd0, 6'd0, 2'd3});
        @(negedge clk);
        check("cfg_busy_pulse", cfg_err, 1);
        @(negedge clk);
        check("cfg_busy_pulse_end", cfg_err, 0);
        get_result(2'd2, 1'b0, 5'd1, "walk_with_rejected_cfg");
        run_dir(8'h80, 2'd2, 1'b0, 5'd1, "rerun_unchanged");

        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = {1'b1, 3'd0, 6'd0, 6'd0, 2'd3};
        send(8'h00);
        cfg_we = 1'b0;
        get_result(2'd3, 1'b0, 5'd0, "same_edge_write");

        load_t2();
        send(8'h80);
        in_valid = 1'b1; in_data = 8'h7F;
        repeat (12) tick();
        @(negedge clk);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_class", out_class, 2);
        check("bp_hold_in_ready", in_ready, 0);
        tick();
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_take", in_ready, 1);
        tick();
        in_valid = 1'b0;
        get_result(2'd1, 1'b0, 5'd1, "bp_next");

        send(8'h80);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_dir(8'h00, 2'd0, 1'b1, 5'd16, "post_reset_timeout");

        rand_phase();

        b_cfg(6'd0, {1'b0, 3'd7, 6'd1, 6'd1, 2'd3}, 1'b0, "b_cfg_ok");
        b_run(5'h1F, 2'd0, 1'b1, 3'd0, "b_illegal_fidx");
        b_cfg(6'd0, {1'b0, 3'd0, 6'd50, 6'd1, 2'd3}, 1'b0, "b_cfg_ok2");
        b_cfg(6'd1, {1'b1, 3'd0, 6'd0, 6'd0, 2'd3}, 1'b0, "b_cfg_ok3");
        b_run(5'h00, 2'd0, 1'b1, 3'd0, "b_illegal_child");
        b_run(5'h01, 2'd3, 1'b0, 3'd1, "b_leaf_via_hi");
        b_cfg(6'd45, {1'b1, 3'd0, 6'd0, 6'd0, 2'd1}, 1'b1, "b_cfg_oob");
        b_cfg(6'd0, 18'd0, 1'b0, "b_cfg_loop");
        b_run(5'h00, 2'd0, 1'b1, 3'd4, "b_timeout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
